// File: rtl/tap_pkg.sv
// tap_pkg: shared TAP state encoding, data-register selectors and opcodes.
// Opcodes are held at the widest legal IR width and narrowed per instance.
package tap_pkg;

  localparam int IR_MAX = 8;

  typedef enum logic [3:0] {
    S_TLR,
    S_RTI,
    S_SEL_DR,
    S_CAP_DR,
    S_SH_DR,
    S_EX1_DR,
    S_PAU_DR,
    S_EX2_DR,
    S_UPD_DR,
    S_SEL_IR,
    S_CAP_IR,
    S_SH_IR,
    S_EX1_IR,
    S_PAU_IR,
    S_EX2_IR,
    S_UPD_IR
  } tap_state_e;

  typedef enum logic [1:0] {
    R_BYPASS,
    R_IDCODE,
    R_USERCODE,
    R_BSR
  } dr_sel_e;

  localparam logic [IR_MAX-1:0] OP_EXTEST   = 8'd0;
  localparam logic [IR_MAX-1:0] OP_IDCODE   = 8'd1;
  localparam logic [IR_MAX-1:0] OP_SAMPLE   = 8'd2;
  localparam logic [IR_MAX-1:0] OP_INTEST   = 8'd3;
  localparam logic [IR_MAX-1:0] OP_USERCODE = 8'd4;

  // BYPASS is all-ones at whatever IR width the instance uses
  function automatic logic [IR_MAX-1:0] op_bypass(int w);
    return {IR_MAX{1'b1}} >> (IR_MAX - w);
  endfunction

endpackage

// File: rtl/tap_fsm.sv
// tap_fsm: IEEE 1149.1 TAP controller state machine.
// Exports one-hot state strobes and a strobe for entering TEST_LOGIC_RESET.
module tap_fsm
  import tap_pkg::*;
(
  input  logic        TCK,
  input  logic        TRST,
  input  logic        TMS,
  output logic [15:0] st,
  output logic        to_tlr
);

  tap_state_e state;
  tap_state_e nxt;

  // State register
  always_ff @(posedge TCK) begin
    if (TRST) state <= S_TLR;
    else      state <= nxt;
  end

  // Next-state on TMS, one-hot strobes
  always_comb begin
    nxt = state;
    unique case (state)
      S_TLR:    nxt = TMS ? S_TLR    : S_RTI;
      S_RTI:    nxt = TMS ? S_SEL_DR : S_RTI;
      S_SEL_DR: nxt = TMS ? S_SEL_IR : S_CAP_DR;
      S_CAP_DR: nxt = TMS ? S_EX1_DR : S_SH_DR;
      S_SH_DR:  nxt = TMS ? S_EX1_DR : S_SH_DR;
      S_EX1_DR: nxt = TMS ? S_UPD_DR : S_PAU_DR;
      S_PAU_DR: nxt = TMS ? S_EX2_DR : S_PAU_DR;
      S_EX2_DR: nxt = TMS ? S_UPD_DR : S_SH_DR;
      S_UPD_DR: nxt = TMS ? S_SEL_DR : S_RTI;
      S_SEL_IR: nxt = TMS ? S_TLR    : S_CAP_IR;
      S_CAP_IR: nxt = TMS ? S_EX1_IR : S_SH_IR;
      S_SH_IR:  nxt = TMS ? S_EX1_IR : S_SH_IR;
      S_EX1_IR: nxt = TMS ? S_UPD_IR : S_PAU_IR;
      S_PAU_IR: nxt = TMS ? S_EX2_IR : S_PAU_IR;
      S_EX2_IR: nxt = TMS ? S_UPD_IR : S_SH_IR;
      S_UPD_IR: nxt = TMS ? S_SEL_DR : S_RTI;
    endcase
    st        = '0;
    st[state] = 1'b1;
    to_tlr    = (nxt == S_TLR);
  end

endmodule

// File: rtl/tap_core.sv
// tap_core: JTAG TAP with IR, BYPASS, IDCODE, boundary scan and TDO mux.
// Define TAP_USERCODE_EN to add the USERCODE register at opcode 4.
module tap_core
  import tap_pkg::*;
#(
  parameter int          IR_WIDTH   = 4,
  parameter int          BSR_WIDTH  = 8,
  parameter logic [31:0] ID_VALUE   = 32'h1000_0001,
  parameter logic [31:0] USER_VALUE = 32'h0000_0000
) (
  input  logic                 TCK,
  input  logic                 TRST,
  input  logic                 TMS,
  input  logic                 TDI,
  output logic                 TDO,
  output logic                 TDO_EN,
  input  logic [BSR_WIDTH-1:0] BSR_PI,
  output logic [BSR_WIDTH-1:0] BSR_PO,
  output logic                 TEST_MODE,
  output logic [IR_WIDTH-1:0]  IR_OUT
);

  localparam logic [IR_WIDTH-1:0] OPC_IDCODE = IR_WIDTH'(OP_IDCODE);
  localparam logic [IR_WIDTH-1:0] OPC_BYPASS =
    IR_WIDTH'(op_bypass(IR_WIDTH));

  logic [15:0]          st;
  logic                 to_tlr;
  logic [IR_WIDTH-1:0]  ir_sh;
  logic                 byp_sh;
  logic [31:0]          id_sh;
  logic [BSR_WIDTH-1:0] bsr_sh;
  logic [IR_MAX-1:0]    ir_ext;
  logic                 ir_ones;
  dr_sel_e              dr_sel;
  logic                 bsr_ins;
  logic                 cap;
  logic                 sh;
  logic                 unused_st;

  tap_fsm u_fsm (
    .TCK    (TCK),
    .TRST   (TRST),
    .TMS    (TMS),
    .st     (st),
    .to_tlr (to_tlr)
  );

  assign ir_ext    = IR_MAX'(IR_OUT);
  assign ir_ones   = (IR_OUT == OPC_BYPASS);
  assign cap       = st[S_CAP_DR];
  assign sh        = st[S_SH_DR];
  assign TDO_EN    = st[S_SH_IR] | st[S_SH_DR];
  assign unused_st = ^st;

`ifdef TAP_USERCODE_EN
  logic [31:0] usr_sh;
`else
  logic unused_user;
  assign unused_user = ^USER_VALUE;
`endif

  // Instruction decode; all-ones wins so narrow IRs still reach BYPASS
  always_comb begin
    dr_sel    = R_BYPASS;
    bsr_ins   = 1'b0;
    TEST_MODE = 1'b0;
    unique case (1'b1)
      ir_ones: dr_sel = R_BYPASS;
      !ir_ones && ir_ext == OP_EXTEST: begin
        dr_sel    = R_BSR;
        bsr_ins   = 1'b1;
        TEST_MODE = 1'b1;
      end
      !ir_ones && ir_ext == OP_IDCODE: dr_sel = R_IDCODE;
      !ir_ones && ir_ext == OP_SAMPLE: begin
        dr_sel  = R_BSR;
        bsr_ins = 1'b1;
      end
      !ir_ones && ir_ext == OP_INTEST: begin
        dr_sel    = R_BSR;
        bsr_ins   = 1'b1;
        TEST_MODE = 1'b1;
      end
`ifdef TAP_USERCODE_EN
      !ir_ones && ir_ext == OP_USERCODE: dr_sel = R_USERCODE;
`endif
      default: dr_sel = R_BYPASS;
    endcase
  end

  // IR capture/shift and active instruction update
  always_ff @(posedge TCK) begin
    if (TRST) begin
      ir_sh  <= '0;
      IR_OUT <= OPC_IDCODE;
    end else begin
      if (st[S_CAP_IR])     ir_sh <= IR_WIDTH'(1);
      else if (st[S_SH_IR]) ir_sh <= {TDI, ir_sh[IR_WIDTH-1:1]};
      if (to_tlr)            IR_OUT <= OPC_IDCODE;
      else if (st[S_UPD_IR]) IR_OUT <= ir_sh;
    end
  end

  // Data registers: only the selected one captures or shifts
  always_ff @(posedge TCK) begin
    if (TRST) begin
      byp_sh <= 1'b0;
      id_sh  <= '0;
      bsr_sh <= '0;
    end else begin
      if (dr_sel == R_BYPASS) begin
        if (cap)     byp_sh <= 1'b0;
        else if (sh) byp_sh <= TDI;
      end
      if (dr_sel == R_IDCODE) begin
        if (cap)     id_sh <= ID_VALUE;
        else if (sh) id_sh <= {TDI, id_sh[31:1]};
      end
      if (dr_sel == R_BSR) begin
        if (cap)     bsr_sh <= BSR_PI;
        else if (sh) bsr_sh <= {TDI, bsr_sh[BSR_WIDTH-1:1]};
      end
    end
  end

`ifdef TAP_USERCODE_EN
  // USERCODE register
  always_ff @(posedge TCK) begin
    if (TRST) begin
      usr_sh <= '0;
    end else if (dr_sel == R_USERCODE) begin
      if (cap)     usr_sh <= USER_VALUE;
      else if (sh) usr_sh <= {TDI, usr_sh[31:1]};
    end
  end
`endif

  // Boundary-scan update latch
  always_ff @(posedge TCK) begin
    if (TRST)                          BSR_PO <= '0;
    else if (st[S_UPD_DR] && bsr_ins) BSR_PO <= bsr_sh;
  end

  // TDO: bit 0 of whatever is shifting, else low
  always_comb begin
    TDO = 1'b0;
    if (st[S_SH_IR]) begin
      TDO = ir_sh[0];
    end else if (sh) begin
      case (dr_sel)
        R_IDCODE:   TDO = id_sh[0];
`ifdef TAP_USERCODE_EN
        R_USERCODE: TDO = usr_sh[0];
`endif
        R_BSR:      TDO = bsr_sh[0];
        default:    TDO = byp_sh;
      endcase
    end
  end

endmodule

// File: tb/tb_tap_core.sv
// tb_tap_core: directed JTAG scans against hand-computed TDO/IR/BSR values.
// Opcode 4 expectations follow TAP_USERCODE_EN.
module tb_tap_core;
  import tap_pkg::*;

  logic       TCK;
  logic       TRST;
  logic       TMS;
  logic       TDI;
  logic       TDO;
  logic       TDO_EN;
  logic [7:0] BSR_PI;
  logic [7:0] BSR_PO;
  logic       TEST_MODE;
  logic [3:0] IR_OUT;

  int n_cmp = 0;
  int n_bad = 0;

  tap_core #(
    .IR_WIDTH   (4),
    .BSR_WIDTH  (8),
    .ID_VALUE   (32'h1000_0001),
    .USER_VALUE (32'hCAFE_0001)
  ) dut (
    .TCK       (TCK),
    .TRST      (TRST),
    .TMS       (TMS),
    .TDI       (TDI),
    .TDO       (TDO),
    .TDO_EN    (TDO_EN),
    .BSR_PI    (BSR_PI),
    .BSR_PO    (BSR_PO),
    .TEST_MODE (TEST_MODE),
    .IR_OUT    (IR_OUT)
  );

  initial TCK = 1'b0;
  always #5 TCK = ~TCK;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    #1;
  endtask

  // From RTI: scan v into IR, return TDO bits and IR_OUT before update
  task automatic load_ir(input logic [3:0] v, output logic [3:0] o,
                         output logic [3:0] irb);
    tick(1, 0);
    tick(1, 0);
    tick(0, 0);
    tick(0, 0);
    for (int i = 0; i < 4; i++) begin
      o[i] = TDO;
      tick(i == 3, v[i]);
    end
    tick(1, 0);
    irb = IR_OUT;
    tick(0, 0);
  endtask

  // From RTI: scan n bits of din through DR, return TDO bits and TDO_EN
  task automatic shift_dr(input int n, input logic [31:0] din,
                          output logic [31:0] dout, output logic en);
    dout = '0;
    en   = 1'b1;
    tick(1, 0);
    tick(0, 0);
    tick(0, 0);
    for (int i = 0; i < n; i++) begin
      dout[i] = TDO;
      en      = en & TDO_EN;
      tick(i == n - 1, din[i]);
    end
    tick(1, 0);
    tick(0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [3:0]  o;
    logic [3:0]  irb;
    logic        en;

    TRST   = 1'b1;
    TMS    = 1'b1;
    TDI    = 1'b0;
    BSR_PI = 8'h00;
    tick(1, 0);
    TRST = 1'b0;
    chk("rst_ir_out", 64'(IR_OUT), 64'h1);
    chk("rst_bsr_po", 64'(BSR_PO), 64'h0);
    chk("rst_tdo", 64'(TDO), 64'h0);
    chk("rst_tdo_en", 64'(TDO_EN), 64'h0);
    chk("rst_test_mode", 64'(TEST_MODE), 64'h0);
    chk("rst_state", 64'(dut.u_fsm.state), 64'(S_TLR));

    tick(0, 0);
    shift_dr(32, 32'h0, d, en);
    chk("idcode_tdo", 64'(d), 64'h1000_0001);
    chk("idcode_tdo_en", 64'(en), 64'h1);
    chk("rti_tdo_en", 64'(TDO_EN), 64'h0);

    load_ir(4'hF, o, irb);
    chk("ir_cap_tdo", 64'(o[1:0]), 64'h1);
    chk("ir_hold", 64'(irb), 64'h1);
    chk("ir_bypass", 64'(IR_OUT), 64'hF);
    shift_dr(4, 32'b1101, d, en);
    chk("bypass_tdo", 64'(d[3:0]), 64'hA);
    chk("bypass_tm", 64'(TEST_MODE), 64'h0);

    load_ir(4'h0, o, irb);
    chk("extest_tm", 64'(TEST_MODE), 64'h1);
    BSR_PI = 8'hA5;
    shift_dr(8, 32'h3C, d, en);
    chk("extest_tdo", 64'(d[7:0]), 64'hA5);
    chk("extest_po", 64'(BSR_PO), 64'h3C);

    load_ir(4'h2, o, irb);
    chk("sample_tm", 64'(TEST_MODE), 64'h0);
    chk("sample_po_hold", 64'(BSR_PO), 64'h3C);
    d = '0;
    tick(1, 0);
    tick(0, 0);
    tick(0, 0);
    for (int i = 0; i < 3; i++) begin
      d[i] = TDO;
      tick(i == 2, 8'h96 >> i);
    end
    tick(0, 0);
    tick(0, 0);
    chk("pause_tdo_en", 64'(TDO_EN), 64'h0);
    tick(1, 0);
    tick(0, 0);
    for (int i = 3; i < 8; i++) begin
      d[i] = TDO;
      tick(i == 7, 8'h96 >> i);
    end
    tick(1, 0);
    tick(0, 0);
    chk("pause_tdo", 64'(d[7:0]), 64'hA5);
    chk("sample_po", 64'(BSR_PO), 64'h96);

    load_ir(4'h3, o, irb);
    chk("intest_tm", 64'(TEST_MODE), 64'h1);

    load_ir(4'h9, o, irb);
    shift_dr(3, 32'b011, d, en);
    chk("unk_bypass_tdo", 64'(d[2:0]), 64'h6);
    chk("unk_po_hold", 64'(BSR_PO), 64'h96);

    load_ir(4'h4, o, irb);
`ifdef TAP_USERCODE_EN
    shift_dr(32, 32'h0, d, en);
    chk("usercode_tdo", 64'(d), 64'hCAFE_0001);
`else
    shift_dr(2, 32'b11, d, en);
    chk("op4_bypass_tdo", 64'(d[1:0]), 64'h2);
`endif
    chk("op4_tm", 64'(TEST_MODE), 64'h0);

    load_ir(4'h0, o, irb);
    tick(1, 0);
    tick(1, 0);
    tick(0, 0);
    tick(0, 0);
    for (int i = 0; i < 5; i++) tick(1, 0);
    chk("tms_rst_state", 64'(dut.u_fsm.state), 64'(S_TLR));
    chk("tms_rst_ir", 64'(IR_OUT), 64'h1);
    chk("tms_rst_po", 64'(BSR_PO), 64'h96);
    chk("tms_rst_tm", 64'(TEST_MODE), 64'h0);

    tick(0, 0);
    load_ir(4'h0, o, irb);
    BSR_PI = 8'hFF;
    tick(1, 0);
    tick(0, 0);
    tick(0, 0);
    for (int i = 0; i < 3; i++) tick(0, 1);
    TRST = 1'b1;
    tick(0, 0);
    TRST = 1'b0;
    chk("trst_po", 64'(BSR_PO), 64'h0);
    chk("trst_ir", 64'(IR_OUT), 64'h1);
    chk("trst_state", 64'(dut.u_fsm.state), 64'(S_TLR));
    chk("trst_tdo_en", 64'(TDO_EN), 64'h0);
    chk("trst_tm", 64'(TEST_MODE), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tap_core.md
TAP_CORE -- requirements
Module: tap_core

Interface
REQ-001 Parameter IR_WIDTH, default 4, instruction register width, legal range 2..8.
REQ-002 Parameter BSR_WIDTH, default 8, boundary-scan cell count, legal range 1..64.
REQ-003 Parameter ID_VALUE, default 32'h1000_0001, IDCODE capture value; bit 0 SHALL be 1.
REQ-004 Parameter USER_VALUE, default 32'h0000_0000, USERCODE capture value.
REQ-005 TCK  input  1  sole clock; all state changes on its rising edge.
REQ-006 TRST  input  1  reset, synchronous, active-high.
REQ-007 TMS  input  1  TAP mode select.
REQ-008 TDI  input  1  serial data in.
REQ-009 TDO  output  1  serial data out.
REQ-010 TDO_EN  output  1  high only in SHIFT_IR or SHIFT_DR.
REQ-011 BSR_PI  input  BSR_WIDTH  pin/core values sampled at CAPTURE_DR.
REQ-012 BSR_PO  output  BSR_WIDTH  update latch driven to pins/core.
REQ-013 TEST_MODE  output  1  high while EXTEST or INTEST is the active instruction.
REQ-014 IR_OUT  output  IR_WIDTH  active (updated) instruction.

Function
REQ-015 FSM SHALL implement all 16 IEEE 1149.1 states and transitions on TMS; five TCKs with TMS=1 SHALL reach TEST_LOGIC_RESET from any state.
REQ-016 CAPTURE_IR SHALL load IR shift register with 1 in bit 0, 0 in all other bits.
REQ-017 SHIFT_IR SHALL shift right one bit per TCK, TDI into MSB, TDO = shift register bit 0.
REQ-018 UPDATE_IR SHALL copy IR shift register to IR_OUT; IR_OUT unchanged in all other states.
REQ-019 Decode: all-zeros EXTEST, 1 IDCODE, 2 SAMPLE, 3 INTEST, 4 USERCODE, all-ones BYPASS; any other value SHALL select BYPASS.
REQ-020 Selected DR: BYPASS 1 bit, IDCODE/USERCODE 32 bits, EXTEST/SAMPLE/INTEST BSR_WIDTH bits.
REQ-021 CAPTURE_DR: BYPASS loads 0; IDCODE loads ID_VALUE; USERCODE loads USER_VALUE; BSR loads BSR_PI.
REQ-022 SHIFT_DR SHALL shift only the selected DR, right, TDI into MSB; unselected DRs hold.
REQ-023 TDO SHALL be the selected register's bit 0 during shift, 0 otherwise; TDO is combinational from registers (zero cycles from register update).
REQ-024 UPDATE_DR with EXTEST, SAMPLE or INTEST SHALL copy BSR shift register to BSR_PO; other instructions leave BSR_PO unchanged.
REQ-025 Transitions through PAUSE states SHALL hold all shift registers.
REQ-026 Entering TEST_LOGIC_RESET via TMS SHALL load IR_OUT with IDCODE, same as reset; BSR_PO holds.

Reset
REQ-027 With TRST high at a TCK edge: FSM TEST_LOGIC_RESET, IR_OUT = IDCODE, IR shift = 0, all DR shift registers 0, BSR_PO 0, TDO 0, TDO_EN 0, TEST_MODE 0.
REQ-028 TRST asserted mid-shift SHALL abort the operation; no partial update reaches IR_OUT or BSR_PO.

Configuration
REQ-029 Macro TAP_USERCODE_EN defined: opcode 4 selects the USERCODE register per REQ-021.
REQ-030 Macro TAP_USERCODE_EN undefined: no USERCODE register exists, opcode 4 decodes as BYPASS, USER_VALUE unused.

Structure
REQ-031 Package tap_pkg SHALL hold the 16-state enum typedef and opcode constants; opcodes SHALL be sized by IR_WIDTH, with BYPASS defined as all-ones.
REQ-032 Sub-module tap_fsm SHALL contain the state register and next-state logic and export one-hot state strobes; tap_core holds IR, DRs and muxing.

Verification
REQ-033 Reset, go to SHIFT_DR without IR scan, shift 32 bits -> TDO sequence = 32'h1000_0001 LSB first.
REQ-034 Load IR 4'hF, shift DR bits 1,0,1,1 -> TDO = 0,1,0,1 (one-cycle bypass delay).
REQ-035 SHIFT_IR 4 cycles -> first two TDO bits 1,0; IR_OUT unchanged until UPDATE_IR.
REQ-036 EXTEST, BSR_PI = 8'hA5, capture, shift in 8'h3C, update -> TDO = A5 LSB first, BSR_PO = 8'h3C, TEST_MODE = 1.
REQ-037 TRST pulse after 3 of 8 BSR shift cycles -> BSR_PO = 0, IR_OUT = IDCODE, state TEST_LOGIC_RESET.
REQ-038 Opcode 4 with TAP_USERCODE_EN and USER_VALUE 32'hCAFE_0001 -> TDO = CAFE_0001; without the macro -> 1-bit bypass behaviour.
